// File: rtl/set_bit_pkg.sv
// Shared types and default sizing for the set-bit position scheduler.
package set_bit_pkg;

  localparam int N_DEF     = 256;
  localparam int LANES_DEF = 4;
  localparam int LOGN_DEF  = (N_DEF > 1) ? $clog2(N_DEF) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef logic [LOGN_DEF-1:0] pos_t;
  typedef logic [LOGN_DEF:0]   cnt_t;

endpackage

// File: rtl/lsb_picker.sv
// Combinational lowest-set-bit finder; returns the index and the mask with that bit removed.
module lsb_picker #(
  parameter int N    = 256,
  parameter int LOGN = 8
) (
  input  logic [N-1:0]    mask,
  output logic            found,
  output logic [LOGN-1:0] idx,
  output logic [N-1:0]    mask_out
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = LOGN'(i);
    end
  end

  assign found    = |mask;
  assign mask_out = mask & (mask - N'(1));

endmodule

// File: rtl/set_bit_scheduler.sv
// Streams the ascending set-bit indices of an accepted mask, up to LANES per beat,
// over a valid/ready output with backpressure.
module set_bit_scheduler
  import set_bit_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int LOGN  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGN-1:0] out_pos,
  output logic [LANES-1:0]      out_lane_en,
  output logic [LOGN:0]         out_base,
  output logic                  out_last,
  output logic                  busy,
  output logic [LOGN:0]         total_count
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SCAN = SCAN;

  logic [0:0]    state;
  logic [N-1:0]  pending;
  logic [LOGN:0] base;
  logic [LOGN:0] lane_cnt;
  logic          accept;
  logic          handshake;

  logic [N-1:0]    chain [LANES+1];
  logic [LOGN-1:0] idx   [LANES];
  logic [LANES-1:0] found;

  function automatic logic [LOGN:0] popcount(input logic [N-1:0] v);
    logic [LOGN:0] acc [N];
    for (int i = 0; i < N; i++) acc[i] = {{LOGN{1'b0}}, v[i]};
    for (int step = 1; step < N; step = step * 2) begin
      for (int i = 0; i + step < N; i = i + 2 * step) acc[i] = acc[i] + acc[i + step];
    end
    return acc[0];
  endfunction

  // Each lane sees pending with all lower lanes' picks already cleared.
  assign chain[0] = pending;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lsb_picker #(.N(N), .LOGN(LOGN)) u_pick (
      .mask     (chain[k]),
      .found    (found[k]),
      .idx      (idx[k]),
      .mask_out (chain[k+1])
    );
    assign out_pos[k*LOGN +: LOGN] = found[k] ? idx[k] : '0;
  end

  always_comb begin
    lane_cnt = '0;
    for (int k = 0; k < LANES; k++) lane_cnt = lane_cnt + {{LOGN{1'b0}}, found[k]};
  end

  assign out_valid   = (state == ST_SCAN);
  assign busy        = (state == ST_SCAN);
  assign out_lane_en = found;
  assign out_base    = base;
  assign out_last    = (chain[LANES] == '0);
  assign handshake   = out_valid & out_ready;
  assign in_ready    = (state == ST_IDLE) | (handshake & out_last);
  assign accept      = in_valid & in_ready;

  // A new accept on the final handshake takes priority so the next mask streams without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      base        <= '0;
      total_count <= '0;
    end else if (accept) begin
      state       <= ST_SCAN;
      pending     <= in_mask;
      base        <= '0;
      total_count <= popcount(in_mask);
    end else if (handshake) begin
      pending <= chain[LANES];
      base    <= base + lane_cnt;
      if (out_last) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_set_bit_scheduler.sv
// Randomized self-checking bench for set_bit_scheduler against a queue-based index model.
module tb_set_bit_scheduler;

  localparam int N     = 256;
  localparam int LANES = 4;
  localparam int LOGN  = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [N-1:0]          in_mask = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [LANES*LOGN-1:0] out_pos;
  logic [LANES-1:0]      out_lane_en;
  logic [LOGN:0]         out_base;
  logic                  out_last;
  logic                  busy;
  logic [LOGN:0]         total_count;

  set_bit_scheduler #(.N(N), .LANES(LANES), .LOGN(LOGN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mask     (in_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .out_lane_en (out_lane_en),
    .out_base    (out_base),
    .out_last    (out_last),
    .busy        (busy),
    .total_count (total_count)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: the remaining indices of the current mask, in ascending order.
  int q[$];
  bit m_busy = 1'b0;
  int m_base = 0;
  int m_total = 0;
  bit last_accept = 1'b0;
  int dut_hs = 0;
  int dut_last_base = -1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input bit v, input logic [N-1:0] m, input bit r);
    int n;
    bit exp_last, exp_in_ready;
    logic [31:0] exp_pos;
    logic [31:0] exp_en;
    @(negedge clk);
    in_valid = v; in_mask = m; out_ready = r;
    #1;
    n = (q.size() < LANES) ? q.size() : LANES;
    exp_last = (q.size() <= LANES);
    exp_pos = '0;
    exp_en  = '0;
    for (int k = 0; k < n; k++) begin
      exp_pos[k*LOGN +: LOGN] = 8'(q[k]);
      exp_en[k] = 1'b1;
    end
    exp_in_ready = !m_busy || (r && exp_last);
    checkOutput("out_valid", 32'(out_valid), 32'(m_busy));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_in_ready));
    checkOutput("total_count", 32'(total_count), 32'(m_total));
    if (m_busy) begin
      checkOutput("out_pos", out_pos, exp_pos);
      checkOutput("out_lane_en", 32'(out_lane_en), exp_en);
      checkOutput("out_base", 32'(out_base), 32'(m_base));
      checkOutput("out_last", 32'(out_last), 32'(exp_last));
    end
    if (out_valid && out_ready) begin
      dut_hs++;
      if (out_last) dut_last_base = int'(out_base);
    end
    last_accept = v && exp_in_ready;
    if (m_busy && r) begin
      repeat (n) void'(q.pop_front());
      m_base += n;
      if (exp_last) m_busy = 1'b0;
    end
    if (last_accept) begin
      q.delete();
      for (int i = 0; i < N; i++) if (m[i]) q.push_back(i);
      m_base  = 0;
      m_total = q.size();
      m_busy  = 1'b1;
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    m_busy = 1'b0; m_base = 0; m_total = 0;
  endtask

  function automatic logic [N-1:0] garbage();
    logic [N-1:0] g;
    for (int w = 0; w < N / 32; w++) g[w*32 +: 32] = $urandom;
    return g;
  endfunction

  function automatic logic [N-1:0] rand_mask(input int kind);
    logic [N-1:0] g;
    g = '0;
    case (kind)
      0: g = '0;
      1: g = '1;
      2: for (int w = 0; w < N / 32; w++) g[w*32 +: 32] = $urandom & $urandom & $urandom;
      3: for (int w = 0; w < N / 32; w++) g[w*32 +: 32] = $urandom;
      default: g[$urandom_range(N - 1, 0)] = 1'b1;
    endcase
    return g;
  endfunction

  function automatic bit pick_ready(input int mode);
    return (mode == 0) ? 1'b1 : 1'(($urandom_range(1, 0)));
  endfunction

  // Offer m until accepted, then drain it; mode 0 keeps out_ready high, mode 1 randomizes it.
  task automatic sendMask(input logic [N-1:0] m, input int mode);
    int guard;
    guard = 0;
    last_accept = 1'b0;
    while (!last_accept && guard < 50) begin
      applyStimulus(1'b1, m, pick_ready(mode));
      guard++;
    end
    if (!last_accept) checkOutput("accept_timeout", 32'd0, 32'd1);
    guard = 0;
    while (m_busy && guard < 500) begin
      applyStimulus(1'b0, garbage(), pick_ready(mode));
      guard++;
    end
    if (m_busy) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [N-1:0] m;
    int tries;

    doReset(2);
    applyStimulus(1'b0, '0, 1'b0);

    m = '0; m[0] = 1'b1; m[5] = 1'b1; m[10] = 1'b1; m[15] = 1'b1;
    sendMask(m, 0);

    m = '0; m[3] = 1'b1; m[7] = 1'b1; m[9] = 1'b1; m[200] = 1'b1; m[255] = 1'b1; m[17] = 1'b1;
    sendMask(m, 0);

    dut_hs = 0;
    sendMask('0, 0);
    checkOutput("empty_beats", 32'(dut_hs), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);

    dut_hs = 0; dut_last_base = -1;
    sendMask('1, 1);
    checkOutput("full_beats", 32'(dut_hs), 32'd64);
    checkOutput("full_last_base", 32'(dut_last_base), 32'd252);

    m = '0; m[1] = 1'b1;
    last_accept = 1'b0;
    tries = 0;
    while (!last_accept && tries < 20) begin
      applyStimulus(1'b1, m, 1'b1);
      tries++;
    end
    m = '0; m[2] = 1'b1; m[4] = 1'b1;
    last_accept = 1'b0;
    tries = 0;
    while (!last_accept && tries < 20) begin
      applyStimulus(1'b1, m, 1'b1);
      tries++;
    end
    checkOutput("b2b_gap", 32'(tries), 32'd1);
    sendMask(m, 0);
    applyStimulus(1'b0, '0, 1'b1);

    m = '0;
    for (int i = 0; i < 10; i++) m[i*7 + 3] = 1'b1;
    last_accept = 1'b0;
    tries = 0;
    while (!last_accept && tries < 20) begin
      applyStimulus(1'b1, m, 1'b1);
      tries++;
    end
    applyStimulus(1'b0, '0, 1'b1);
    doReset(1);
    applyStimulus(1'b0, '0, 1'b1);
    m = '0; m[40] = 1'b1; m[41] = 1'b1; m[90] = 1'b1; m[91] = 1'b1; m[250] = 1'b1;
    sendMask(m, 0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(2, 0)) applyStimulus(1'b0, garbage(), 1'(($urandom_range(1, 0))));
      sendMask(rand_mask($urandom_range(4, 0)), int'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
